vga_sync_ctrl: RTL
==================

VGA_SYNC_CTRL -- requirements
Module: vga_sync_ctrl

Interface
REQ-001 Parameter H_DISPLAY, default 640: active pixels per line.
REQ-002 Parameter H_FRONT / H_SYNC / H_BACK, defaults 16 / 96 / 48: horizontal porch and sync widths in pixels; line total 800.
REQ-003 Parameter V_DISPLAY, default 480: active lines per frame.
REQ-004 Parameter V_FRONT / V_SYNC / V_BACK, defaults 10 / 2 / 33: vertical porch and sync widths in lines; frame total 525.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk  in  1  system clock, 50 MHz.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 upd_req  in  1  level request from game/robot logic to update scene registers.
REQ-009 hsync  out  1  horizontal sync, active low.
REQ-010 vsync  out  1  vertical sync, active low.
REQ-011 video_on  out  1  high inside the visible area.
REQ-012 p_tick  out  1  one-clk pixel strobe, every 2nd clk.
REQ-013 pix_x  out  10  current column (0..799).
REQ-014 pix_y  out  10  current row (0..524).
REQ-015 frame_tick  out  1  one-clk pulse at end of frame.
REQ-016 upd_gnt  out  1  update grant, only ever high during vertical blanking.
REQ-017 upd_late  out  1  one-clk pulse when a grant is revoked by the end of blanking.

Function
REQ-018 A 1-bit phase register SHALL toggle every clk; p_tick = phase==1, so the first p_tick occurs on the 2nd clk after reset release.
REQ-019 On p_tick, h_count SHALL increment; at 799 it SHALL wrap to 0 and v_count SHALL increment; v_count SHALL wrap from 524 to 0.
REQ-020 Counters SHALL hold their value on clks without p_tick.
REQ-021 pix_x/pix_y SHALL equal h_count/v_count registers directly, with zero latency.
REQ-022 video_on SHALL be (h_count<640)&&(v_count<480), aligned with pix_x/pix_y.
REQ-023 hsync SHALL be registered, low exactly while h_count is in 656..751, and cycle-aligned with h_count.
REQ-024 vsync SHALL be registered, low exactly while v_count is in 490..491, and cycle-aligned with v_count.
REQ-025 frame_tick SHALL be high for the clk where p_tick && h_count==799 && v_count==524.
REQ-026 vblank SHALL be defined as v_count>=480.
REQ-027 The grant FSM SHALL have the states IDLE, WAIT and GRANT; upd_gnt SHALL be registered and high only in GRANT.
REQ-028 IDLE: when upd_req=1, the FSM SHALL go to WAIT.
REQ-029 WAIT: when upd_req=0, the FSM SHALL go to IDLE; otherwise, when vblank=1, it SHALL go to GRANT (upd_gnt rises the following clk).
REQ-030 GRANT: when upd_req=0, the FSM SHALL go to IDLE (upd_gnt low the following clk).
REQ-031 GRANT: when vblank=0 and upd_req=1, the FSM SHALL go to WAIT and pulse upd_late for one clk.
REQ-032 If upd_req drops in the same clk that vblank ends, the FSM SHALL go to IDLE with no upd_late.
REQ-033 A request held across frames SHALL be re-granted at each vblank start.

Reset
REQ-034 On reset, phase, h_count and v_count SHALL be 0; hsync=1, vsync=1, p_tick=0, frame_tick=0, upd_gnt=0, upd_late=0; the FSM SHALL be in IDLE.
REQ-035 Reset asserted mid-frame or mid-grant SHALL take effect at the next clk edge, dropping upd_gnt at once and restarting the timing from (0,0).

Structure
REQ-036 Timing constants (display, porch and sync widths, totals) and FSM state encodings SHALL live in the shared package vga_params, shared with the pixel generator.
REQ-037 The phase/p_tick divider SHALL be a sub-module named pix_tick_gen; everything else SHALL stay flat.

Verification
REQ-038 Release reset, run 2*800*525 clks -> exactly one frame_tick, at clk 840000 after release; pix_x/pix_y back to (0,0).
REQ-039 Sample each p_tick over one line -> 640 p_ticks with video_on=1 per visible line; hsync low for 96 p_ticks, falling when pix_x goes 655->656.
REQ-040 Over one frame -> vsync low only for rows 490 and 491 (2*800 p_ticks); video_on=0 for rows 480..524.
REQ-041 Assert upd_req at row 100 and hold it -> upd_gnt rises 1 clk after v_count becomes 480; at the wrap to row 0, upd_gnt falls and upd_late pulses once; grant returns at the next row 480.
REQ-042 Assert upd_req during vblank, drop it after 10 clks -> upd_gnt high for 10 clks, then the FSM goes to IDLE with no upd_late.
REQ-043 Assert reset during GRANT at row 500 -> next clk: upd_gnt=0, pix_x=pix_y=0, hsync=vsync=1.

Source files
------------

// File: rtl/vga_params.sv
// Shared VGA timing constants and grant FSM encodings, used by the sync
// controller and the pixel generator.
package vga_params;

  localparam int CNT_W = 10;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_H_TOTAL   = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_V_TOTAL   = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GRANT = 2'd2
  } grant_state_t;

endpackage

// File: rtl/pix_tick_gen.sv
// Divide-by-two pixel strobe: phase toggles every clk, p_tick marks phase==1.
module pix_tick_gen (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  logic phase;

  always_ff @(posedge clk) begin
    if (reset) phase <= 1'b0;
    else       phase <= ~phase;
  end

  assign p_tick = phase;

endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA raster timing (counters, syncs, visible window) plus a vblank-gated
// scene-update grant handshake.
//
// state    | meaning
// ST_IDLE  | no update requested
// ST_WAIT  | request pending, waiting for vertical blanking
// ST_GRANT | update granted, scene registers may be written
module vga_sync_ctrl
  import vga_params::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             upd_req,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             p_tick,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             frame_tick,
  output logic             upd_gnt,
  output logic             upd_late
);

  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [CNT_W-1:0] h_count, v_count, h_next, v_next;
  logic             vblank;
  grant_state_t     state, state_next;
  logic             late_d;

  pix_tick_gen u_pix_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  always_comb begin
    h_next = h_count;
    v_next = v_count;
    if (p_tick) begin
      if (h_count == H_MAX) begin
        h_next = '0;
        v_next = (v_count == V_MAX) ? '0 : v_count + CNT_W'(1);
      end else begin
        h_next = h_count + CNT_W'(1);
      end
    end
  end

  // Syncs are decoded from the next count so they stay aligned with the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
    end else begin
      h_count <= h_next;
      v_count <= v_next;
      hsync   <= !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
      vsync   <= !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
    end
  end

  assign pix_x      = h_count;
  assign pix_y      = v_count;
  assign video_on   = (h_count < H_VIS) && (v_count < V_VIS);
  assign vblank     = (v_count >= V_VIS);
  assign frame_tick = p_tick && (h_count == H_MAX) && (v_count == V_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      upd_gnt  <= 1'b0;
      upd_late <= 1'b0;
    end else begin
      state    <= state_next;
      upd_gnt  <= (state_next == ST_GRANT);
      upd_late <= late_d;
    end
  end

  // A dropped request always wins, so losing blanking then never flags late.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (upd_req) state_next = ST_WAIT;
      ST_WAIT: begin
        if (!upd_req)    state_next = ST_IDLE;
        else if (vblank) state_next = ST_GRANT;
      end
      ST_GRANT: begin
        if (!upd_req)     state_next = ST_IDLE;
        else if (!vblank) state_next = ST_WAIT;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    late_d = 1'b0;
    if ((state == ST_GRANT) && upd_req && !vblank) late_d = 1'b1;
  end

endmodule
